// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM and ALU/immediate decode for a multicycle RV32I datapath
module multicycle_controller #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             RegWrite,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BEQ      = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;
  localparam logic [3:0] ILLEGAL  = 4'd11;
  logic [3:0] state, next;
  logic       rdy, pc_update, branch, ir_write, mem_write, reg_write, retire;
  logic [1:0] alu_op;
  assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign retire = (state == MEMWB) | (state == ALUWB) | (state == BEQ) | ((state == MEMWRITE) & rdy);
  assign illegal = (state == ILLEGAL);
  // Enables are masked by rst_n so nothing can write while reset is asserted
  assign PCWrite  = rst_n & (pc_update | (branch & zero));
  assign IRWrite  = rst_n & ir_write;
  assign MemWrite = rst_n & mem_write;
  assign RegWrite = rst_n & reg_write;
  // Next-state selection; memory states stall until the access completes
  always_comb begin
    next = ILLEGAL;
    case (state)
      FETCH:    next = rdy ? DECODE : FETCH;
      DECODE:   case (op)
                  7'b0000011, 7'b0100011: next = MEMADR;
                  7'b0110011:             next = EXECR;
                  7'b0010011:             next = EXECI;
                  7'b1100011:             next = BEQ;
                  7'b1101111:             next = JAL;
                  default:                next = ILLEGAL;
                endcase
      MEMADR:   next = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  next = rdy ? MEMWB : MEMREAD;
      MEMWB:    next = FETCH;
      MEMWRITE: next = rdy ? FETCH : MEMWRITE;
      EXECR:    next = ALUWB;
      EXECI:    next = ALUWB;
      ALUWB:    next = FETCH;
      BEQ:      next = FETCH;
      JAL:      next = ALUWB;
      default:  next = ILLEGAL;
    endcase
  end
  // Moore decode of datapath controls; FETCH also qualifies its enables with rdy
  always_comb begin
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    case (state)
      FETCH:    begin ALUSrcB = 2'b10; ResultSrc = 2'b10; ir_write = rdy; pc_update = rdy; end
      DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB:    begin ResultSrc = 2'b01; reg_write = 1'b1; end
      MEMWRITE: begin AdrSrc = 1'b1; mem_write = 1'b1; end
      EXECR:    begin ALUSrcA = 2'b10; alu_op = 2'b10; end
      EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; alu_op = 2'b10; end
      ALUWB:    reg_write = 1'b1;
      BEQ:      begin ALUSrcA = 2'b10; alu_op = 2'b01; branch = 1'b1; end
      JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_update = 1'b1; end
      default:  ;
    endcase
  end
  // ALU operation: funct3 decode for ALU instructions; only R-type can subtract
  always_comb begin
    ALUControl = 3'b000;
    if (alu_op == 2'b01) ALUControl = 3'b001;
    else if (alu_op == 2'b10)
      case (funct3)
        3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
        3'b010:  ALUControl = 3'b101;
        3'b110:  ALUControl = 3'b011;
        3'b111:  ALUControl = 3'b010;
        default: ALUControl = 3'b000;
      endcase
  end
  // Immediate format follows the opcode in every state
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end
  // State register and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      retired <= '0;
    end else begin
      state   <= next;
      retired <= retire ? retired + CNT_W'(1) : retired;
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven instruction runs with a scoreboard plus reset/illegal sequences
module tb_multicycle_controller;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, zero, mem_ready;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] retired;

  multicycle_controller #(.MEM_WAIT_EN(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .RegWrite(RegWrite),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [31:0] rdy;
    int          cyc, irw, pcw, regw, memw;
    logic [2:0]  alu;
    logic [1:0]  imm;
  } vec_t;

  typedef struct {
    int         cyc, irw, pcw, regw, memw;
    logic [2:0] alu;
    logic [1:0] imm;
  } exp_t;

  localparam int NV = 13;
  vec_t tbl [NV];
  exp_t q [$];
  int   compared = 0;
  int   mismatched = 0;
  int   exp_ret = 0;

  task automatic chk(input string nm, input int idx, input longint act, input longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, req);
    end
  endtask

  // Runs one instruction starting in FETCH; alu=111 means no rs1-based ALU cycle was seen
  task automatic run(input int k);
    exp_t        e;
    logic [31:0] r;
    logic [2:0]  alu;
    logic [1:0]  imm;
    int          c, irw, pcw, regw, memw;
    bit          nf, done;
    q.push_back('{tbl[k].cyc, tbl[k].irw, tbl[k].pcw, tbl[k].regw, tbl[k].memw, tbl[k].alu, tbl[k].imm});
    op = tbl[k].op; funct3 = tbl[k].f3; funct7b5 = tbl[k].f7; zero = tbl[k].z;
    r = tbl[k].rdy;
    alu = 3'b111; imm = 2'b00; irw = 0; pcw = 0; regw = 0; memw = 0; nf = 0; done = 0;
    for (c = 0; c < 40; c++) begin
      mem_ready = (c < 32) ? r[c[4:0]] : 1'b1;
      #1;
      if (c == 0) imm = ImmSrc;
      if (nf && ResultSrc == 2'b10) begin done = 1; break; end
      if (ResultSrc != 2'b10) nf = 1;
      irw  += int'(IRWrite);
      pcw  += int'(PCWrite);
      regw += int'(RegWrite);
      memw += int'(MemWrite);
      if (ALUSrcA == 2'b10) alu = ALUControl;
      @(negedge clk);
    end
    if (!done) begin
      mismatched++;
      $display("FAIL timeout[%0d]: instruction did not return to FETCH within 40 cycles", k);
    end
    e = q.pop_front();
    chk("cycles", k, c, e.cyc);
    chk("irwrite", k, irw, e.irw);
    chk("pcwrite", k, pcw, e.pcw);
    chk("regwrite", k, regw, e.regw);
    chk("memwrite", k, memw, e.memw);
    chk("alucontrol", k, alu, e.alu);
    chk("immsrc", k, imm, e.imm);
    exp_ret++;
    chk("retired", k, retired, exp_ret);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         op          f3      f7    z     rdy           cyc irw pcw rw mw  alu     imm
    tbl[0]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 32'hFFFFFFFF, 4, 1, 1, 1, 0, 3'b000, 2'b00};
    tbl[1]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 32'hFFFFFFFF, 4, 1, 1, 1, 0, 3'b001, 2'b00};
    tbl[2]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 32'hFFFFFFFF, 4, 1, 1, 1, 0, 3'b000, 2'b00};
    tbl[3]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 32'hFFFFFFFF, 4, 1, 1, 1, 0, 3'b101, 2'b00};
    tbl[4]  = '{7'b0010011, 3'b110, 1'b0, 1'b0, 32'hFFFFFFFF, 4, 1, 1, 1, 0, 3'b011, 2'b00};
    tbl[5]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 32'hFFFFFFFF, 4, 1, 1, 1, 0, 3'b010, 2'b00};
    tbl[6]  = '{7'b0010011, 3'b100, 1'b0, 1'b0, 32'hFFFFFFFF, 4, 1, 1, 1, 0, 3'b000, 2'b00};
    tbl[7]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 32'hFFFFFFE7, 7, 1, 1, 1, 0, 3'b000, 2'b00};
    tbl[8]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 32'hFFFFFFE7, 6, 1, 1, 0, 3, 3'b000, 2'b01};
    tbl[9]  = '{7'b1100011, 3'b000, 1'b0, 1'b1, 32'hFFFFFFFF, 3, 1, 2, 0, 0, 3'b001, 2'b10};
    tbl[10] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 32'hFFFFFFFF, 3, 1, 1, 0, 0, 3'b001, 2'b10};
    tbl[11] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 32'hFFFFFFFF, 4, 1, 2, 1, 0, 3'b111, 2'b11};
    tbl[12] = '{7'b0110011, 3'b000, 1'b0, 1'b0, 32'hFFFFFFFC, 6, 1, 1, 1, 0, 3'b000, 2'b00};
    rst_n = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_enables", i, {PCWrite, IRWrite, MemWrite, RegWrite}, 0);
      chk("rst_retired", i, retired, 0);
      chk("rst_illegal", i, illegal, 0);
      chk("rst_fetch", i, ResultSrc, 2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NV; k++) run(k);
    op = 7'h7F; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1)); zero = 1'b1;
      #1;
      chk("ill_flag", i, illegal, 1);
      chk("ill_enables", i, {PCWrite, IRWrite, MemWrite, RegWrite}, 0);
      @(negedge clk);
    end
    chk("ill_retired", 0, retired, exp_ret);
    rst_n = 1'b0; #1;
    chk("ill_clear", 0, illegal, 0);
    chk("ill_rst_retired", 0, retired, 0);
    @(negedge clk);
    rst_n = 1'b1; exp_ret = 0;
    run(0);
    op = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("mw_held", 0, MemWrite, 1);
    mem_ready = 1'b1; rst_n = 1'b0; #1;
    chk("mw_abort_enables", 0, {PCWrite, IRWrite, MemWrite, RegWrite}, 0);
    chk("mw_abort_retired", 0, retired, 0);
    chk("mw_abort_fetch", 0, ResultSrc, 2);
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk("mw_restart_ir", 0, IRWrite, 1);
    exp_ret = 0;
    run(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
